// File: rtl/id_pipe.sv
// RV32I integer-subset decode stage with ID/EX register, scoreboard
// interlock and optional write-back bypass onto the operand buses.
module id_pipe #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            wb_wen_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic [3:0]      alu_op_o,
  output logic            illegal_o
);

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_SLL  = 4'd2;
  localparam logic [3:0] A_SLT  = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4;
  localparam logic [3:0] A_XOR  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_OR   = 4'd8;
  localparam logic [3:0] A_AND  = 4'd9;
  localparam logic [3:0] A_BEQ  = 4'd10;
  localparam logic [3:0] A_BNE  = 4'd11;
  localparam logic [3:0] A_BLT  = 4'd12;
  localparam logic [3:0] A_BGE  = 4'd13;

  typedef enum logic [1:0] {K_RR, K_IMM, K_SH, K_LUI} kind_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            wen;
    logic [3:0]      alu;
    logic            ill;
  } id_ex_t;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic            w_opi, w_op, w_br, w_lui;
  logic            w_u1, w_u2, w_wr, w_ill;
  logic [3:0]      w_alu;
  kind_e           w_kind;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_a, w_b, w_imm, w_sh, w_luiv;
  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_hit1, w_hit2, w_hitd, w_byp1, w_byp2;
  logic            w_haz, w_acc, w_hs, w_set;
  logic [31:0]     w_sb_nxt;
  id_ex_t          w_q;

  logic            r_valid;
  id_ex_t          r_q;
  logic [31:0]     r_sb;

  assign w_opc = inst_i[6:0];
  assign w_f3  = inst_i[14:12];
  assign w_f7  = inst_i[31:25];
  assign w_opi = (w_opc == 7'b0010011);
  assign w_op  = (w_opc == 7'b0110011);
  assign w_br  = (w_opc == 7'b1100011);
  assign w_lui = (w_opc == 7'b0110111);

  always_comb begin
    w_u1   = 1'b0;
    w_u2   = 1'b0;
    w_wr   = 1'b0;
    w_ill  = 1'b0;
    w_alu  = A_ADD;
    w_kind = K_RR;
    unique case (1'b1)
      w_opi: begin
        w_u1   = 1'b1;
        w_wr   = 1'b1;
        w_kind = K_IMM;
        case (w_f3)
          3'b000: w_alu = A_ADD;
          3'b010: w_alu = A_SLT;
          3'b011: w_alu = A_SLTU;
          3'b100: w_alu = A_XOR;
          3'b110: w_alu = A_OR;
          3'b111: w_alu = A_AND;
          3'b001: begin
            w_kind = K_SH;
            w_alu  = A_SLL;
            w_ill  = (w_f7 != 7'h00);
          end
          3'b101: begin
            w_kind = K_SH;
            w_alu  = w_f7[5] ? A_SRA : A_SRL;
            w_ill  = ((w_f7 & ~7'h20) != 7'h00);
          end
        endcase
      end
      w_op: begin
        w_u1 = 1'b1;
        w_u2 = 1'b1;
        w_wr = 1'b1;
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: w_alu = A_ADD;
          {7'h20, 3'b000}: w_alu = A_SUB;
          {7'h00, 3'b001}: w_alu = A_SLL;
          {7'h00, 3'b010}: w_alu = A_SLT;
          {7'h00, 3'b011}: w_alu = A_SLTU;
          {7'h00, 3'b100}: w_alu = A_XOR;
          {7'h00, 3'b101}: w_alu = A_SRL;
          {7'h20, 3'b101}: w_alu = A_SRA;
          {7'h00, 3'b110}: w_alu = A_OR;
          {7'h00, 3'b111}: w_alu = A_AND;
          default:         w_ill = 1'b1;
        endcase
      end
      w_br: begin
        w_u1 = 1'b1;
        w_u2 = 1'b1;
        case (w_f3)
          3'b000:  w_alu = A_BEQ;
          3'b001:  w_alu = A_BNE;
          3'b100:  w_alu = A_BLT;
          3'b101:  w_alu = A_BGE;
          default: w_ill = 1'b1;
        endcase
      end
      w_lui: begin
        w_wr   = 1'b1;
        w_kind = K_LUI;
      end
      default: w_ill = 1'b1;
    endcase
    // illegal words travel downstream as an inert bubble
    if (w_ill) begin
      w_u1  = 1'b0;
      w_u2  = 1'b0;
      w_wr  = 1'b0;
      w_alu = A_ADD;
    end
  end

  assign w_rs1 = w_u1 ? inst_i[19:15] : 5'd0;
  assign w_rs2 = w_u2 ? inst_i[24:20] : 5'd0;
  assign w_rd  = w_wr ? inst_i[11:7]  : 5'd0;
  assign rs1_addr_o = w_rs1;
  assign rs2_addr_o = w_rs2;

  assign w_byp1 = BYPASS & wb_wen_i & (wb_rd_i == w_rs1);
  assign w_byp2 = BYPASS & wb_wen_i & (wb_rd_i == w_rs2);

  assign w_a = (w_rs1 == 5'd0) ? '0 : w_byp1 ? wb_data_i : rs1_data_i;
  assign w_b = (w_rs2 == 5'd0) ? '0 : w_byp2 ? wb_data_i : rs2_data_i;

  assign w_imm  = XLEN'($signed(inst_i[31:20]));
  assign w_sh   = XLEN'(inst_i[24:20]);
  assign w_luiv = XLEN'($signed({inst_i[31:12], 12'h000}));

  always_comb begin
    w_op1 = w_a;
    w_op2 = w_b;
    unique case (w_kind)
      K_RR:  ;
      K_IMM: w_op2 = w_imm;
      K_SH:  w_op2 = w_sh;
      K_LUI: begin
        w_op1 = '0;
        w_op2 = w_luiv;
      end
    endcase
    if (w_ill) begin
      w_op1 = '0;
      w_op2 = '0;
    end
  end

  assign w_hit1 = r_valid & r_q.wen & (r_q.rd == w_rs1) & (w_rs1 != 5'd0);
  assign w_hit2 = r_valid & r_q.wen & (r_q.rd == w_rs2) & (w_rs2 != 5'd0);
  assign w_hitd = r_valid & r_q.wen & (r_q.rd == w_rd) & (w_rd != 5'd0);

  assign w_haz = (r_sb[w_rs1] & ~w_byp1) | w_hit1
               | (r_sb[w_rs2] & ~w_byp2) | w_hit2
               | r_sb[w_rd] | w_hitd;

  assign in_ready = flush_i | ((~r_valid | out_ready) & ~w_haz);
  assign w_acc    = in_valid & in_ready & ~flush_i;
  assign w_hs     = r_valid & out_ready;
  assign w_set    = w_hs & ~flush_i & r_q.wen & (r_q.rd != 5'd0);

  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_wen_i) w_sb_nxt[wb_rd_i] = 1'b0;
    if (w_set)    w_sb_nxt[r_q.rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_comb begin
    w_q      = '0;
    w_q.inst = inst_i;
    w_q.pc   = inst_addr_i;
    w_q.op1  = w_op1;
    w_q.op2  = w_op2;
    w_q.rd   = w_rd;
    w_q.wen  = w_wr;
    w_q.alu  = w_alu;
    w_q.ill  = w_ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_sb    <= '0;
    end else begin
      r_sb <= w_sb_nxt;
      if (w_acc) r_q <= w_q;
      if (flush_i)    r_valid <= 1'b0;
      else if (w_acc) r_valid <= 1'b1;
      else if (w_hs)  r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign inst_o      = r_q.inst;
  assign inst_addr_o = r_q.pc;
  assign op1_o       = r_q.op1;
  assign op2_o       = r_q.op2;
  assign rd_addr_o   = r_q.rd;
  assign reg_wen_o   = r_q.wen;
  assign alu_op_o    = r_q.alu;
  assign illegal_o   = r_q.ill;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: one instance without and one with bypass, each
// tracked by an ISA-level model of decode, in-flight writes and regfile.
module tb_id_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  alu;
    logic        ill;
  } bnd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_vld[2], s_ordy[2], s_wen[2], s_fl[2];
  logic [31:0] s_inst[2], s_pc[2], s_wdat[2];
  logic [4:0]  s_wrd[2];

  logic        in_ready[2], out_valid[2], reg_wen[2], ill[2];
  logic [4:0]  rs1a[2], rs2a[2], rd_o[2];
  logic [31:0] rs1d[2], rs2d[2], inst_o[2], pc_o[2], op1[2], op2[2];
  logic [3:0]  alu[2];

  logic [31:0] rf[2][32];
  bit          infl[2][32];
  bit          mv[2];
  bnd_t        mb[2];
  bit          acc[2], hs[2];
  bnd_t        nb[2];

  int n_vec = 0;
  int n_bad = 0;

  id_pipe #(.XLEN(32), .BYPASS(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_vld[0]), .in_ready(in_ready[0]),
    .inst_i(s_inst[0]), .inst_addr_i(s_pc[0]),
    .rs1_addr_o(rs1a[0]), .rs2_addr_o(rs2a[0]),
    .rs1_data_i(rs1d[0]), .rs2_data_i(rs2d[0]),
    .wb_wen_i(s_wen[0]), .wb_rd_i(s_wrd[0]), .wb_data_i(s_wdat[0]),
    .flush_i(s_fl[0]),
    .out_valid(out_valid[0]), .out_ready(s_ordy[0]),
    .inst_o(inst_o[0]), .inst_addr_o(pc_o[0]),
    .op1_o(op1[0]), .op2_o(op2[0]),
    .rd_addr_o(rd_o[0]), .reg_wen_o(reg_wen[0]),
    .alu_op_o(alu[0]), .illegal_o(ill[0])
  );

  id_pipe #(.XLEN(32), .BYPASS(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_vld[1]), .in_ready(in_ready[1]),
    .inst_i(s_inst[1]), .inst_addr_i(s_pc[1]),
    .rs1_addr_o(rs1a[1]), .rs2_addr_o(rs2a[1]),
    .rs1_data_i(rs1d[1]), .rs2_data_i(rs2d[1]),
    .wb_wen_i(s_wen[1]), .wb_rd_i(s_wrd[1]), .wb_data_i(s_wdat[1]),
    .flush_i(s_fl[1]),
    .out_valid(out_valid[1]), .out_ready(s_ordy[1]),
    .inst_o(inst_o[1]), .inst_addr_o(pc_o[1]),
    .op1_o(op1[1]), .op2_o(op2[1]),
    .rd_addr_o(rd_o[1]), .reg_wen_o(reg_wen[1]),
    .alu_op_o(alu[1]), .illegal_o(ill[1])
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rs1d[d] = rf[d][rs1a[d]];
      rs2d[d] = rf[d][rs2a[d]];
    end
  end

  task automatic chk(input string tag, input logic [159:0] got,
                     input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bnd_t obs(input int d);
    return {inst_o[d], pc_o[d], op1[d], op2[d],
            rd_o[d], reg_wen[d], alu[d], ill[d]};
  endfunction

  // ISA table: alu code and operand kind (0 rr, 1 imm, 2 shamt, 3 lui)
  function automatic void ref_dec(input logic [31:0] i,
                                  output bit u1, output bit u2,
                                  output bit wr, output int a,
                                  output int k);
    a = 0;
    k = -1;
    casez ({i[31:25], i[14:12], i[6:0]})
      17'b???????_000_0010011: begin a = 0;  k = 1; end
      17'b???????_010_0010011: begin a = 3;  k = 1; end
      17'b???????_011_0010011: begin a = 4;  k = 1; end
      17'b???????_100_0010011: begin a = 5;  k = 1; end
      17'b???????_110_0010011: begin a = 8;  k = 1; end
      17'b???????_111_0010011: begin a = 9;  k = 1; end
      17'b0000000_001_0010011: begin a = 2;  k = 2; end
      17'b0000000_101_0010011: begin a = 6;  k = 2; end
      17'b0100000_101_0010011: begin a = 7;  k = 2; end
      17'b0000000_000_0110011: begin a = 0;  k = 0; end
      17'b0100000_000_0110011: begin a = 1;  k = 0; end
      17'b0000000_001_0110011: begin a = 2;  k = 0; end
      17'b0000000_010_0110011: begin a = 3;  k = 0; end
      17'b0000000_011_0110011: begin a = 4;  k = 0; end
      17'b0000000_100_0110011: begin a = 5;  k = 0; end
      17'b0000000_101_0110011: begin a = 6;  k = 0; end
      17'b0100000_101_0110011: begin a = 7;  k = 0; end
      17'b0000000_110_0110011: begin a = 8;  k = 0; end
      17'b0000000_111_0110011: begin a = 9;  k = 0; end
      17'b???????_000_1100011: begin a = 10; k = 0; end
      17'b???????_001_1100011: begin a = 11; k = 0; end
      17'b???????_100_1100011: begin a = 12; k = 0; end
      17'b???????_101_1100011: begin a = 13; k = 0; end
      17'b???????_???_0110111: begin a = 0;  k = 3; end
      default: ;
    endcase
    u1 = (k >= 0) && (k != 3);
    u2 = (k == 0);
    wr = (k >= 0) && (i[6:0] != 7'h63);
  endfunction

  function automatic logic [31:0] srcv(input int d, input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (d == 1 && s_wen[d] && s_wrd[d] == r) return s_wdat[d];
    return rf[d][r];
  endfunction

  function automatic bit hit(input int d, input logic [4:0] r);
    return r != 5'd0 && mv[d] && mb[d].wen && mb[d].rd == r;
  endfunction

  task automatic settle();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit u1, u2, wr, haz, rdy;
      int a, k;
      logic [4:0] r1, r2, rd;
      logic [31:0] va, vb;
      ref_dec(s_inst[d], u1, u2, wr, a, k);
      r1 = u1 ? s_inst[d][19:15] : 5'd0;
      r2 = u2 ? s_inst[d][24:20] : 5'd0;
      rd = wr ? s_inst[d][11:7] : 5'd0;
      haz = 0;
      if (r1 != 0 && ((infl[d][r1] &&
          !(d == 1 && s_wen[d] && s_wrd[d] == r1)) || hit(d, r1)))
        haz = 1;
      if (r2 != 0 && ((infl[d][r2] &&
          !(d == 1 && s_wen[d] && s_wrd[d] == r2)) || hit(d, r2)))
        haz = 1;
      if (rd != 0 && (infl[d][rd] || hit(d, rd))) haz = 1;
      rdy = s_fl[d] || ((!mv[d] || s_ordy[d]) && !haz);
      chk($sformatf("in_ready%0d", d), in_ready[d], rdy);
      chk($sformatf("rs1_addr%0d", d), rs1a[d], r1);
      chk($sformatf("rs2_addr%0d", d), rs2a[d], r2);
      acc[d] = s_vld[d] && rdy && !s_fl[d];
      hs[d]  = mv[d] && s_ordy[d];
      va = srcv(d, r1);
      vb = srcv(d, r2);
      nb[d] = '0;
      nb[d].inst = s_inst[d];
      nb[d].pc   = s_pc[d];
      if (k < 0) nb[d].ill = 1'b1;
      else begin
        nb[d].rd  = rd;
        nb[d].wen = wr;
        nb[d].alu = a[3:0];
        case (k)
          0: begin nb[d].op1 = va; nb[d].op2 = vb; end
          1: begin nb[d].op1 = va; nb[d].op2 = $signed(s_inst[d]) >>> 20; end
          2: begin nb[d].op1 = va; nb[d].op2 = {27'd0, s_inst[d][24:20]}; end
          default: nb[d].op2 = s_inst[d] & 32'hFFFF_F000;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (s_wen[d] && s_wrd[d] != 0) begin
        rf[d][s_wrd[d]] = s_wdat[d];
        infl[d][s_wrd[d]] = 0;
      end
      if (hs[d] && !s_fl[d] && mb[d].wen && mb[d].rd != 0)
        infl[d][mb[d].rd] = 1;
      if (s_fl[d]) mv[d] = 0;
      else if (acc[d]) begin
        mv[d] = 1;
        mb[d] = nb[d];
      end else if (hs[d]) mv[d] = 0;
      chk($sformatf("out_valid%0d", d), out_valid[d], mv[d]);
      chk($sformatf("idex%0d", d), obs(d), mb[d]);
    end
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 0; s_inst[d] = 0; s_pc[d] = 0; s_ordy[d] = 1;
      s_wen[d] = 0; s_wrd[d] = 0; s_wdat[d] = 0; s_fl[d] = 0;
    end
  endtask

  task automatic gen_wb(input int d, input int pct);
    s_wen[d] = 0;
    s_wrd[d] = 0;
    s_wdat[d] = $urandom;
    if ($urandom_range(99) < pct) begin
      int st = $urandom_range(31);
      for (int j = 0; j < 32; j++) begin
        int r = (st + j) % 32;
        if (infl[d][r]) begin
          s_wen[d] = 1;
          s_wrd[d] = r[4:0];
          break;
        end
      end
    end
    if (!s_wen[d] && $urandom_range(99) < 4) begin
      s_wen[d] = 1;
      s_wrd[d] = 5'($urandom_range(7, 1));
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    r1 = 5'($urandom_range(7));
    r2 = 5'($urandom_range(7));
    rd = 5'($urandom_range(7));
    f3 = 3'($urandom_range(7));
    imm = 12'($urandom);
    f7 = 7'h00;
    case ($urandom_range(9))
      0, 1, 2: begin
        if (f3 == 3'b001) imm[11:5] = 7'h00;
        else if (f3 == 3'b101) imm[11:5] = $urandom_range(1) ? 7'h20 : 7'h00;
        return {imm, r1, f3, rd, 7'h13};
      end
      3, 4, 5: begin
        if ((f3 == 3'b000 || f3 == 3'b101) && $urandom_range(1)) f7 = 7'h20;
        return {f7, r2, r1, f3, rd, 7'h33};
      end
      6: return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
      7: return {20'($urandom), rd, 7'h37};
      8: return {7'($urandom), r2, r1, f3, rd, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    bit busy;
    idle();
    for (int c = 0; c < 64; c++) begin
      for (int d = 0; d < 2; d++) gen_wb(d, 100);
      settle();
      tick();
      busy = 0;
      for (int d = 0; d < 2; d++) begin
        if (mv[d]) busy = 1;
        for (int r = 0; r < 32; r++) if (infl[d][r]) busy = 1;
      end
      if (!busy) break;
    end
    idle();
    chk("drain_done", busy, 1'b0);
  endtask

  task automatic send(input logic [31:0] inst);
    bit done[2];
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 1; s_inst[d] = inst; s_pc[d] = 32'h100;
      s_ordy[d] = 1; s_fl[d] = 0; done[d] = 0;
    end
    for (int c = 0; c < 60; c++) begin
      for (int d = 0; d < 2; d++) gen_wb(d, 50);
      settle();
      tick();
      for (int d = 0; d < 2; d++) if (acc[d]) begin
        done[d] = 1;
        s_vld[d] = 0;
      end
      if (done[0] && done[1]) break;
    end
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 0;
      s_wen[d] = 0;
    end
    chk("send_done", {done[0], done[1]}, 2'b11);
  endtask

  initial begin
    idle();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0;
      mb[d] = '0;
      for (int r = 0; r < 32; r++) begin
        rf[d][r] = 32'd0;
        infl[d][r] = 0;
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", out_valid[d], 1'b0);
      chk("rst_outputs", obs(d), 160'd0);
    end
    settle();
    tick();

    // ADDI x1,x0,5 then ADD x2,x1,x1 resolved by write-back
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 1; s_inst[d] = 32'h0050_0093; s_pc[d] = 32'h0;
    end
    settle();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("addi_op1", op1[d], 32'd0);
      chk("addi_op2", op2[d], 32'd5);
      chk("addi_rd", rd_o[d], 5'd1);
      chk("addi_wen", reg_wen[d], 1'b1);
      chk("addi_alu", alu[d], 4'd0);
      s_inst[d] = 32'h0010_8133;
      s_pc[d] = 32'h4;
    end
    settle();
    for (int d = 0; d < 2; d++) chk("add_held_stall", in_ready[d], 1'b0);
    tick();
    settle();
    for (int d = 0; d < 2; d++) chk("add_sb_stall", in_ready[d], 1'b0);
    tick();
    for (int d = 0; d < 2; d++) begin
      s_wen[d] = 1; s_wrd[d] = 5'd1; s_wdat[d] = 32'd5;
    end
    settle();
    chk("byp_accept", in_ready[1], 1'b1);
    chk("nobyp_wait", in_ready[0], 1'b0);
    tick();
    chk("byp_op1", op1[1], 32'd5);
    chk("byp_op2", op2[1], 32'd5);
    chk("byp_rd", rd_o[1], 5'd2);
    s_vld[1] = 0;
    for (int d = 0; d < 2; d++) s_wen[d] = 0;
    settle();
    chk("nobyp_accept", in_ready[0], 1'b1);
    tick();
    chk("nobyp_op1", op1[0], 32'd5);
    chk("nobyp_op2", op2[0], 32'd5);
    chk("nobyp_rd", rd_o[0], 5'd2);
    drain();

    // hold under backpressure, then release
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 1; s_inst[d] = 32'h0070_0193; s_ordy[d] = 0;
    end
    settle();
    tick();
    for (int d = 0; d < 2; d++) s_inst[d] = 32'h0090_0213;
    for (int c = 0; c < 3; c++) begin
      settle();
      for (int d = 0; d < 2; d++) chk("hold_ready", in_ready[d], 1'b0);
      tick();
      for (int d = 0; d < 2; d++) chk("hold_inst", inst_o[d], 32'h0070_0193);
    end
    for (int d = 0; d < 2; d++) s_ordy[d] = 1;
    settle();
    tick();
    for (int d = 0; d < 2; d++) chk("release_inst", inst_o[d], 32'h0090_0213);

    // flush a held instruction: its rd must not become pending
    for (int d = 0; d < 2; d++) begin
      s_ordy[d] = 0; s_fl[d] = 1; s_inst[d] = 32'h0010_0293;
    end
    settle();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("flush_valid", out_valid[d], 1'b0);
      s_fl[d] = 0; s_ordy[d] = 1; s_inst[d] = 32'h0042_0333;
    end
    settle();
    for (int d = 0; d < 2; d++) chk("flush_sb", in_ready[d], 1'b1);
    tick();
    drain();

    send(32'hFFFF_FFFF);
    for (int d = 0; d < 2; d++) begin
      chk("ill_flag", ill[d], 1'b1);
      chk("ill_wen", reg_wen[d], 1'b0);
      chk("ill_rd", rd_o[d], 5'd0);
    end
    send(32'h4020_8133);
    for (int d = 0; d < 2; d++) chk("sub_alu", alu[d], 4'd1);
    drain();

    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        s_vld[d] = ($urandom_range(4) != 0);
        s_inst[d] = gen_inst();
        s_pc[d] = $urandom & 32'hFFFF_FFFC;
        s_fl[d] = ($urandom_range(99) < 4);
        s_ordy[d] = s_fl[d] ? 1'b0 : ($urandom_range(99) < 75);
        gen_wb(d, 40);
      end
      settle();
      tick();
    end

    // asynchronous reset in the middle of a stall
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 1; s_inst[d] = 32'h0050_0093; s_ordy[d] = 0;
      s_fl[d] = 0; s_wen[d] = 0;
    end
    settle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_valid", out_valid[d], 1'b0);
      chk("async_rst_out", obs(d), 160'd0);
      mv[d] = 0;
      mb[d] = '0;
      for (int r = 0; r < 32; r++) infl[d][r] = 0;
    end
    rst_n = 1'b1;
    idle();
    settle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, handshaked instruction-decode stage with a register scoreboard and write-back bypass. It is the parametrised successor to the phase-1 combinational decoder and sits between the IF/ID boundary and the execute stage. It decodes the RV32I integer subset into operands and an ALU opcode, interlocks on read-after-write and write-after-write hazards, and holds its result in an internal ID/EX register with valid/ready flow control.

## Interface
- XLEN, 32: operand/data width; immediates sign-extend to XLEN.
- BYPASS, 1: 1 = write-back data satisfies a pending read in the same cycle; 0 = wait one more cycle for the regfile write.

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts instruction this cycle
- inst_i  in  32  instruction word
- inst_addr_i  in  XLEN  instruction PC
- rs1_addr_o, rs2_addr_o  out  5 each  combinational regfile read addresses (0 when field unused)
- rs1_data_i, rs2_data_i  in  XLEN  regfile read data, same cycle
- wb_wen_i, wb_rd_i, wb_data_i  in  1/5/XLEN  write-back bus
- flush_i  in  1  kill held and incoming instruction
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  execute accepts
- inst_o, inst_addr_o  out  32/XLEN  registered copies
- op1_o, op2_o  out  XLEN  operands
- rd_addr_o  out  5; reg_wen_o  out  1
- alu_op_o  out  4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE
- illegal_o  out  1  unsupported encoding

## Operation
- Decoded: OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (all ten R-type), BRANCH (BEQ, BNE, BLT, BGE), LUI.
- OP-IMM: op1 = rs1 value, op2 = sext(imm[11:0]); shifts use op2 = shamt zero-extended. OP: op1/op2 = rs1/rs2 values. BRANCH: both register values, rd = 0, reg_wen = 0. LUI: op1 = 0, op2 = sext(imm[31:12]<<12), ALU ADD.
- Any other encoding: illegal_o = 1, reg_wen = 0, rd = 0, op1 = op2 = 0, alu_op = 0; still passes downstream.
- Operand source: x0 always reads 0; if BYPASS and wb_wen_i and wb_rd_i == rs (rs != 0), use wb_data_i; otherwise regfile data.
- Scoreboard: 32-bit pending mask, bit 0 hard-wired 0. Set bit rd on output handshake (out_valid & out_ready) when reg_wen_o and rd != 0. Clear bit wb_rd_i on wb_wen_i. Same-cycle set and clear of the same bit: set wins.
- Hazard (combinational on incoming instruction): a used rs1/rs2, or rd when reg_wen, is pending in the scoreboard or equals the held out_valid instruction's rd with reg_wen_o. With BYPASS = 1, a pending source cleared by this cycle's write-back is not a hazard. The held-instruction match is always a hazard.
- in_ready = flush_i | ((!out_valid | out_ready) & !hazard).
- Accept (in_valid & in_ready & !flush_i): load ID/EX register, out_valid = 1. Output handshake without accept: out_valid = 0. Otherwise hold all outputs stable.
- flush_i: out_valid = 0 next cycle. The incoming instruction is discarded. The scoreboard is not modified, because unissued instructions never set bits. Write-back clears still apply.

## Timing
- Reset: out_valid 0; inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, alu_op_o, reg_wen_o, illegal_o all 0; scoreboard 0.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle when hazard-free.
- RAW on write-back: with BYPASS = 1, accept in the write-back cycle. With BYPASS = 0, accept the cycle after.
- out_valid & !out_ready: every output is stable until the handshake.
- rs*_addr_o follow inst_i combinationally, even while stalled.
- Reset mid-stall or mid-flush: state clears immediately, asynchronously.

## Test plan
- Reset, then hold rst_n high with no input -> out_valid = 0, in_ready = 1, all outputs 0.
- inst 0x00500093 (ADDI x1,x0,5) at PC 0x0 -> next cycle op1 = 0, op2 = 5, rd = 1, reg_wen = 1, alu_op = 0. Issue it, and scoreboard bit 1 sets.
- Then 0x00108133 (ADD x2,x1,x1) -> in_ready = 0 until wb_wen_i = 1, wb_rd_i = 1, wb_data_i = 5. With BYPASS = 1 it is accepted that cycle, op1 = op2 = 5, rd = 2. Repeat with BYPASS = 0 and expect acceptance one cycle later.
- Valid ADDI held with out_ready = 0 for 3 cycles -> outputs unchanged, in_ready = 0. Release -> handshake, and the next instruction loads.
- out_valid = 1 with flush_i and in_valid both 1 -> next cycle out_valid = 0, scoreboard unchanged.
- inst 0xFFFFFFFF -> illegal_o = 1, reg_wen = 0, rd = 0. 0x40208133 (SUB) -> alu_op = 1.
